// File: rtl/keccak_squeeze_pkg.sv
// rtl/keccak_squeeze_pkg.sv - shared Keccak sizes and squeeze FSM types
package keccak_squeeze_pkg;

  localparam int STATE_WIDTH         = 1600;
  localparam int RATE                = 1088;
  localparam int OUT_WIDTH           = 32;
  localparam int LEN_WIDTH           = 16;
  localparam int SQZ_WORDS_PER_BLOCK = RATE / OUT_WIDTH;
  localparam int SQZ_CNT_WIDTH       = $clog2(SQZ_WORDS_PER_BLOCK + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, WAIT, FIN} sqz_state_t;

endpackage

// File: rtl/keccak_squeeze.sv
// rtl/keccak_squeeze.sv - sponge squeeze driver streaming rate words, re-triggering the core
// Optional overlap of next permutation with draining: KECCAK_SQUEEZE_PREFETCH_EN.
module keccak_squeeze
  import keccak_squeeze_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESETN,
  input  logic                   START,
  input  logic [LEN_WIDTH-1:0]   REQ_WORDS,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   KECCAK_ENABLE,
  input  logic                   KECCAK_DONE,
  input  logic [STATE_WIDTH-1:0] KECCAK_STATE,
  output logic [OUT_WIDTH-1:0]   DOUT,
  output logic                   DOUT_VALID,
  input  logic                   DOUT_READY
);

  localparam logic [SQZ_CNT_WIDTH-1:0] AVAIL_FULL = SQZ_CNT_WIDTH'(SQZ_WORDS_PER_BLOCK);
  localparam logic [SQZ_CNT_WIDTH-1:0] AVAIL_ONE  = SQZ_CNT_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]     BLOCK_LEN  = LEN_WIDTH'(SQZ_WORDS_PER_BLOCK);
  localparam logic [LEN_WIDTH-1:0]     REM_ONE    = LEN_WIDTH'(1);

  sqz_state_t               state;
  logic [RATE-1:0]          rate_buf;
  logic [LEN_WIDTH-1:0]     rem;
  logic [SQZ_CNT_WIDTH-1:0] avail;
  logic                     handshake;
  logic                     unused_capacity_bits;
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
  logic                     pending;
`endif

  // Capacity lanes never leave the block.
  assign unused_capacity_bits = ^KECCAK_STATE[STATE_WIDTH-RATE-1:0];
  assign handshake            = DOUT_VALID && DOUT_READY;
  assign DOUT                 = rate_buf[RATE-1 -: OUT_WIDTH];

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state         <= IDLE;
      rate_buf      <= '0;
      rem           <= '0;
      avail         <= '0;
      BUSY          <= 1'b0;
      DONE          <= 1'b0;
      KECCAK_ENABLE <= 1'b0;
      DOUT_VALID    <= 1'b0;
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
      pending       <= 1'b0;
`endif
    end else begin
      DONE          <= 1'b0;
      KECCAK_ENABLE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            if (REQ_WORDS != '0) begin
              rate_buf   <= KECCAK_STATE[STATE_WIDTH-1 -: RATE];
              rem        <= REQ_WORDS;
              avail      <= AVAIL_FULL;
              DOUT_VALID <= 1'b1;
              BUSY       <= 1'b1;
              state      <= DRAIN;
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
              KECCAK_ENABLE <= (REQ_WORDS > BLOCK_LEN);
              pending       <= 1'b0;
`endif
            end else begin
              DONE <= 1'b1;
            end
          end
        end
        DRAIN: begin
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
          if (KECCAK_DONE) pending <= 1'b1;
`endif
          if (handshake) begin
            rate_buf <= rate_buf << OUT_WIDTH;
            rem      <= rem - REM_ONE;
            avail    <= avail - AVAIL_ONE;
            if (rem == REM_ONE) begin
              DOUT_VALID <= 1'b0;
              DONE       <= 1'b1;
              state      <= FIN;
            end else if (avail == AVAIL_ONE) begin
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
              // Next block already permuted: swap it in with no valid gap.
              if (pending || KECCAK_DONE) begin
                rate_buf      <= KECCAK_STATE[STATE_WIDTH-1 -: RATE];
                avail         <= AVAIL_FULL;
                pending       <= 1'b0;
                KECCAK_ENABLE <= ((rem - REM_ONE) > BLOCK_LEN);
              end else begin
                DOUT_VALID <= 1'b0;
                state      <= WAIT;
              end
`else
              KECCAK_ENABLE <= 1'b1;
              DOUT_VALID    <= 1'b0;
              state         <= WAIT;
`endif
            end
          end
        end
        WAIT: begin
          if (KECCAK_DONE) begin
            rate_buf   <= KECCAK_STATE[STATE_WIDTH-1 -: RATE];
            avail      <= AVAIL_FULL;
            DOUT_VALID <= 1'b1;
            state      <= DRAIN;
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
            KECCAK_ENABLE <= (rem > BLOCK_LEN);
            pending       <= 1'b0;
`endif
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// tb/tb_keccak_squeeze.sv - randomized self-checking bench for keccak_squeeze
module tb_keccak_squeeze;
  localparam int W = 1088 / 32;

  logic          CLK = 1'b0;
  logic          RESETN, START, KECCAK_DONE, DOUT_READY;
  logic [15:0]   REQ_WORDS;
  logic          BUSY, DONE, KECCAK_ENABLE, DOUT_VALID;
  logic [1599:0] KECCAK_STATE;
  logic [31:0]   DOUT;

  keccak_squeeze dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .REQ_WORDS(REQ_WORDS),
    .BUSY(BUSY), .DONE(DONE), .KECCAK_ENABLE(KECCAK_ENABLE),
    .KECCAK_DONE(KECCAK_DONE), .KECCAK_STATE(KECCAK_STATE),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY)
  );

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  int init_seq = 0, req_cur = 0, core_lat = 10, core_cnt = 0;
  int hs = 0, en_cnt = 0, nblk = 0;
  bit rand_ready = 0;
  logic [1599:0] init_blk, known_state;
  logic [1599:0] blocks [8];

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1599:0] rand_state();
    logic [1599:0] s = '0;
    for (int i = 0; i < 50; i++) s = {s[1567:0], $urandom()};
    return s;
  endfunction

  function automatic logic [31:0] word_of(input logic [1599:0] b, input int j);
    return b[1599 - 32*j -: 32];
  endfunction

  // Consumer readiness
  initial begin
    DOUT_READY = 1'b1;
    forever begin
      @(posedge CLK); #1;
      DOUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Core model: each enable yields a fresh random block after core_lat cycles
  initial begin
    int last_seq = 0;
    KECCAK_DONE = 1'b0;
    KECCAK_STATE = '0;
    forever begin
      @(posedge CLK); #1;
      KECCAK_DONE = 1'b0;
      if (init_seq != last_seq) begin
        last_seq = init_seq;
        KECCAK_STATE = init_blk;
        blocks[0] = init_blk;
        nblk = 1;
      end
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          KECCAK_STATE = rand_state();
          KECCAK_DONE = 1'b1;
          if (nblk < 8) blocks[nblk] = KECCAK_STATE;
          nblk++;
        end
      end else if (KECCAK_ENABLE) begin
        core_cnt = core_lat;
      end
    end
  end

  // Every-cycle compare against the block-sequence model
  initial begin
    int cmp_seq = 0;
    bit p_valid = 0, p_ready = 0, p_hs = 0, p_kdone = 0;
    logic [31:0] p_dout = '0, ew;
    forever begin
      @(negedge CLK);
      if (init_seq != cmp_seq) begin
        cmp_seq = init_seq; hs = 0; en_cnt = 0;
        p_valid = 0; p_ready = 0; p_hs = 0; p_kdone = 0;
      end
      if (DOUT_VALID) begin
        if (hs >= req_cur) check(1'b0, "extra_word", 64'(hs), 64'(req_cur));
        else if (hs / W >= nblk) check(1'b0, "word_before_block", 64'(hs), 64'(nblk));
        else begin
          ew = word_of(blocks[hs / W], hs % W);
          check(DOUT == ew, "dout_data", DOUT, ew);
        end
      end
      if (p_valid && !p_ready)
        check(DOUT_VALID && DOUT == p_dout, "hold_stable", {31'd0, DOUT_VALID, DOUT}, {32'd1, p_dout});
      if (DONE && req_cur != 0)
        check(p_hs && hs == req_cur, "done_timing", 64'(hs), 64'(req_cur));
`ifndef KECCAK_SQUEEZE_PREFETCH_EN
      if (p_hs && hs > 0 && hs % W == 0 && hs < req_cur)
        check(KECCAK_ENABLE, "refill_enable", 64'(KECCAK_ENABLE), 64'd1);
      if (p_kdone && BUSY)
        check(DOUT_VALID, "refill_resume", 64'(DOUT_VALID), 64'd1);
`endif
      p_hs = DOUT_VALID && DOUT_READY;
      if (p_hs) hs++;
      if (KECCAK_ENABLE) en_cnt++;
      p_valid = DOUT_VALID; p_ready = DOUT_READY; p_dout = DOUT; p_kdone = KECCAK_DONE;
    end
  end

  task automatic launch(input int req, input int lat, input bit rnd, input bit known);
    int guard = 0;
    while ((core_cnt != 0 || KECCAK_DONE) && guard < 200) begin
      @(posedge CLK); #1; guard++;
    end
    init_blk = known ? known_state : rand_state();
    req_cur = req; core_lat = lat; rand_ready = rnd;
    init_seq++;
    @(posedge CLK); #1;
    START = 1'b1; REQ_WORDS = 16'(req);
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run(input int req, input int lat, input bit rnd, input bit known, output int cyc);
    bit done_seen = 0;
    launch(req, lat, rnd, known);
    cyc = 0;
    while (!done_seen && cyc < 3000) begin
      @(negedge CLK); cyc++;
      if (cyc == 1) begin
        if (req > 0) check(DOUT_VALID, "first_valid", 64'(DOUT_VALID), 64'd1);
        else         check(DONE, "zero_done", 64'(DONE), 64'd1);
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
        if (req > W) check(KECCAK_ENABLE, "prefetch_enable", 64'(KECCAK_ENABLE), 64'd1);
`endif
        if (known) check(DOUT == 32'hCAFEF00D, "known_word0", DOUT, 32'hCAFEF00D);
      end
      if (known && cyc == 5) check(DOUT == 32'h0BADC0DE, "known_word4", DOUT, 32'h0BADC0DE);
      if (DONE) done_seen = 1;
    end
    check(done_seen, "done_timeout", 64'(cyc), 64'd3000);
    #1;
    check(hs == req, "handshakes", 64'(hs), 64'(req));
    check(en_cnt == (req == 0 ? 0 : (req - 1) / W), "enable_count", 64'(en_cnt), 64'(req == 0 ? 0 : (req - 1) / W));
    @(negedge CLK);
    check(!BUSY && !DOUT_VALID, "busy_drop", {BUSY, DOUT_VALID}, 64'd0);
  endtask

  initial begin
    int c, guard;
    bit ok;
    RESETN = 1'b0; START = 1'b0; REQ_WORDS = '0;
    known_state = '0;
    known_state[1599 -: 160] = {32'hCAFEF00D, 32'h01234567, 32'h89ABCDEF, 32'h5A5A5A5A, 32'h0BADC0DE};
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check(!BUSY, "rst_busy", 64'(BUSY), 64'd0);
    check(!DONE, "rst_done", 64'(DONE), 64'd0);
    check(!KECCAK_ENABLE, "rst_enable", 64'(KECCAK_ENABLE), 64'd0);
    check(!DOUT_VALID, "rst_valid", 64'(DOUT_VALID), 64'd0);
    check(DOUT == 32'd0, "rst_dout", DOUT, 64'd0);
    @(posedge CLK); #1 RESETN = 1'b1;

    run(5, 10, 0, 1, c);
    check(c == 6, "known_done_cycle", 64'(c), 64'd6);
    run(40, 12, 0, 0, c);
    run(34, 8, 1, 0, c);
    run(0, 8, 0, 0, c);

    // Reset in the middle of a multi-block request
    launch(70, 20, 0, 0);
    guard = 0;
    while (en_cnt == 0 && guard < 200) begin @(negedge CLK); guard++; end
    check(en_cnt > 0, "reset_setup", 64'(en_cnt), 64'd1);
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b0;
    @(posedge CLK); #1 RESETN = 1'b1;
    @(negedge CLK);
    check({BUSY, DONE, KECCAK_ENABLE, DOUT_VALID} == 4'b0 && DOUT == 32'd0, "reset_outputs",
          {BUSY, DONE, KECCAK_ENABLE, DOUT_VALID, DOUT}, 64'd0);
    ok = 1;
    repeat (40) begin
      @(negedge CLK);
      if (BUSY || DOUT_VALID || DONE || KECCAK_ENABLE) ok = 0;
    end
    check(ok, "stray_done_ignored", 64'(ok), 64'd1);
    check(core_cnt == 0, "stray_done_seen", 64'(core_cnt), 64'd0);

    run(7, 5, 1, 0, c);
    repeat (6) run($urandom_range(1, 80), $urandom_range(1, 30), 1, 0, c);
`ifdef KECCAK_SQUEEZE_PREFETCH_EN
    run(68, 24, 0, 0, c);
    check(c == 69, "no_bubble", 64'(c), 64'd69);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/keccak_squeeze.md
# keccak_squeeze

Output-side sponge driver for the KECCAK permutation core. It captures the rate part of the permuted state and streams it as OUT_WIDTH-bit words over a valid/ready handshake. It re-triggers the core whenever more output is needed than one block holds. It sits between the KECCAK core and the BIKE samplers that consume SHAKE256 XOF output.

## Interface
- STATE_WIDTH, 1600, Keccak state width in bits.
- RATE, 1088, sponge rate in bits (SHAKE256); RATE % OUT_WIDTH == 0 required.
- OUT_WIDTH, 32, output word width.
- LEN_WIDTH, 16, width of the requested-word count.
- Reset RESETN, synchronous, active-low; clock CLK.
- CLK  in  1  clock.
- RESETN  in  1  synchronous active-low reset.
- START  in  1  one-cycle request; core state already holds the first permuted output block.
- REQ_WORDS  in  LEN_WIDTH  number of words to emit; sampled on START.
- BUSY  out  1  high from accepted START until DONE.
- DONE  out  1  one-cycle pulse after the last word is accepted.
- KECCAK_ENABLE  out  1  one-cycle pulse that starts a permutation.
- KECCAK_DONE  in  1  one-cycle pulse from the core; state is stable from then until the next enable.
- KECCAK_STATE  in  STATE_WIDTH  core output vector; byte 0 is at the MSB.
- DOUT  out  OUT_WIDTH  output word.
- DOUT_VALID  out  1  DOUT holds valid data.
- DOUT_READY  in  1  consumer accepts DOUT.

## Operation
- Block size: W = RATE/OUT_WIDTH words (34 at defaults).
- Rate buffer: RATE bits, loaded from KECCAK_STATE[STATE_WIDTH-1 -: RATE].
- Word order: DOUT = buffer MSB word; the buffer shifts left by OUT_WIDTH on each handshake (DOUT_VALID && DOUT_READY).
- Counters:
  - rem (LEN_WIDTH bits): words still owed.
  - avail ($clog2(W+1) bits): words left in the buffer.
- FSM states:
  - IDLE:
    - START with REQ_WORDS != 0: capture the buffer, rem = REQ_WORDS, avail = W, go to DRAIN.
    - START with REQ_WORDS == 0: pulse DONE next cycle, stay in IDLE.
  - DRAIN: DOUT_VALID = 1. On each handshake, rem--, avail--.
    - rem reaches 0: go to FIN.
    - avail reaches 0 with rem > 0: pulse KECCAK_ENABLE, go to WAIT.
  - WAIT: DOUT_VALID = 0. On KECCAK_DONE, capture the buffer, avail = W, go to DRAIN.
  - FIN: pulse DONE, return to IDLE.
- START is ignored when not in IDLE.
- KECCAK_DONE in IDLE or FIN is ignored.
- DOUT and DOUT_VALID stay stable while DOUT_VALID && !DOUT_READY.
- The final block may be partially drained; the remaining buffer contents are discarded.
- RESETN low in any state: return to IDLE next edge.
  - All outputs go to 0; buffer, rem and avail are cleared.
  - A permutation already running in the core is not tracked; its KECCAK_DONE arrives in IDLE and is ignored.

## Timing
- Reset values: BUSY, DONE, KECCAK_ENABLE, DOUT_VALID = 0; DOUT = 0.
- START at edge t → DOUT_VALID = 1 and first word on DOUT from t+1.
- Throughput is one word per cycle while DOUT_READY is held high within a block.
- Refill (no prefetch):
  - Handshake of word W-1 at t → KECCAK_ENABLE high during t+1.
  - KECCAK_DONE seen at edge d → DOUT_VALID from d+1.
- Last handshake at t → DONE high during t+1 (FIN); BUSY low from t+2.
- All outputs are registered.

## Configuration
- KECCAK_SQUEEZE_PREFETCH_EN defined:
  - Pulse KECCAK_ENABLE the cycle after each capture if rem > avail, so the next permutation runs while the buffer drains.
  - A KECCAK_DONE received while avail > 0 sets a pending flag.
  - When avail reaches 0, capture in the same cycle and keep DOUT_VALID high, giving a zero-bubble transition.
  - WAIT is entered only when the pending flag is clear.
- Undefined: refill only after the buffer empties, as described above.
- The emitted data sequence is identical in both builds.

## Structure
- KECCAK_PACKAGE adds:
  - SQZ_WORDS_PER_BLOCK = RATE/OUT_WIDTH.
  - SQZ_CNT_WIDTH = $clog2(SQZ_WORDS_PER_BLOCK+1).
  - typedef enum sqz_state_t {IDLE, DRAIN, WAIT, FIN}.
  - STATE_WIDTH and RATE are already in the package.
- Single RTL module with no sub-modules.
- rem and avail are down-counters local to the block; BIKE_counter_inc (up-counting) is not reused.

## Test plan
- START with REQ_WORDS=5, DOUT_READY=1, KECCAK_STATE=known vector → 5 words equal to state bits [1599:1440] in 32-bit MSB-first order, DONE 1 cycle after the 5th, no KECCAK_ENABLE.
- REQ_WORDS=40 → 34 words, one KECCAK_ENABLE pulse, stall until KECCAK_DONE, then 6 words from the new state, DONE.
- Random DOUT_READY gaps with REQ_WORDS=34 → DOUT held stable whenever not ready; exactly 34 handshakes; zero KECCAK_ENABLE pulses.
- REQ_WORDS=0 → DONE pulse at t+1, DOUT_VALID never high.
- RESETN low during WAIT with REQ_WORDS=70 → all outputs 0 next cycle; the later KECCAK_DONE is ignored; a new START works normally.
- PREFETCH_EN, REQ_WORDS=68, core latency 24 cycles, DOUT_READY=1 → 68 consecutive valid cycles with no bubble; KECCAK_ENABLE at t+1 after START.
